prga_core: RTL and testbench

// - ARC4 pseudo-random generation algorithm (PRGA) stage of the ARC4 decryption datapath.
// - Runs after the KSA stage has scrambled S.
// - Reads length-prefixed ciphertext, generates the keystream from S, and writes length-prefixed plaintext.
// - Talks to three external single-port 256x8 memories (S, CT, PT) and handshakes with the top-level controller via en/rdy.

---
 rtl/prga_core_if.sv | 63 ++++++
 rtl/prga_core.sv | 232 +++++++++++++++++++++++
 tb/tb_prga_core.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prga_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : prga_core_if
//  Description : Controller handshake plus the S / CT / PT memory ports of the
//                ARC4 PRGA stage.
//                master = PRGA core side, slave = controller/memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface prga_core_if;
    // Controller handshake
    logic        en;
    logic        rdy;
    logic [23:0] key;

    // S memory (read/write)
    logic [7:0]  s_addr;
    logic [7:0]  s_rddata;
    logic [7:0]  s_wrdata;
    logic        s_wren;

    // Ciphertext memory (read only)
    logic [7:0]  ct_addr;
    logic [7:0]  ct_rddata;

    // Plaintext memory (write only from this stage)
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata;
    logic [7:0]  pt_wrdata;
    logic        pt_wren;

    modport master (
        input  en,
        input  key,
        input  s_rddata,
        input  ct_rddata,
        input  pt_rddata,
        output rdy,
        output s_addr,
        output s_wrdata,
        output s_wren,
        output ct_addr,
        output pt_addr,
        output pt_wrdata,
        output pt_wren
    );

    modport slave (
        output en,
        output key,
        output s_rddata,
        output ct_rddata,
        output pt_rddata,
        input  rdy,
        input  s_addr,
        input  s_wrdata,
        input  s_wren,
        input  ct_addr,
        input  pt_addr,
        input  pt_wrdata,
        input  pt_wren
    );
endinterface
`default_nettype wire

// File: rtl/prga_core.sv
`default_nettype none
// ============================================================================
//  Module      : prga_core
//  Description : ARC4 pseudo-random generation stage. Reads a length-prefixed
//                ciphertext from CT, runs the ARC4 keystream over the already
//                keyed S memory, and writes length-prefixed plaintext to PT.
//                All three memories are single-port with one-cycle read
//                latency; every memory-side output is registered.
//  Revision    : 1.0  initial release
// ============================================================================
module prga_core (
    input  logic        clk,
    input  logic        rst_n,    // synchronous, active-high despite the name
    prga_core_if.master bus
);

    typedef enum logic [4:0] {
        ST_IDLE   = 5'd0,
        ST_RD_LEN = 5'd1,
        ST_WT_LEN = 5'd2,
        ST_WR_LEN = 5'd3,
        ST_INC_I  = 5'd4,
        ST_RD_SI  = 5'd5,
        ST_WT_SI  = 5'd6,
        ST_CALC_J = 5'd7,
        ST_RD_SJ  = 5'd8,
        ST_WT_SJ  = 5'd9,
        ST_WR_SI  = 5'd10,
        ST_WR_SJ  = 5'd11,
        ST_RD_PAD = 5'd12,
        ST_WT_PAD = 5'd13,
        ST_RD_CT  = 5'd14,
        ST_WT_CT  = 5'd15,
        ST_WR_PT  = 5'd16
    } state_t;

    state_t     state_q;

    // Algorithm registers
    logic [7:0] i_q;
    logic [7:0] j_q;
    logic [7:0] k_q;
    logic [7:0] length_q;
    logic [7:0] si_q;
    logic [7:0] sj_q;
    logic [7:0] pad_q;

    // Registered memory-side outputs
    logic       rdy_q;
    logic [7:0] s_addr_q;
    logic [7:0] s_wrdata_q;
    logic       s_wren_q;
    logic [7:0] ct_addr_q;
    logic [7:0] pt_addr_q;
    logic [7:0] pt_wrdata_q;
    logic       pt_wren_q;

    // Next-value arithmetic; 8-bit width gives the mod-256 wrap for free
    logic [7:0] i_d;
    logic [7:0] j_d;
    logic [7:0] pad_idx_d;
    logic [7:0] k_d;

    assign i_d       = i_q + 8'd1;
    assign j_d       = j_q + si_q;
    assign pad_idx_d = si_q + sj_q;
    assign k_d       = k_q + 8'd1;

    // S is keyed upstream and PT is never read back by this stage
    logic w_unused;
    assign w_unused = ^{bus.key, bus.pt_rddata};

    assign bus.rdy       = rdy_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.pt_wrdata = pt_wrdata_q;
    assign bus.pt_wren   = pt_wren_q;

    // Sequencer: one memory access per state; outputs for the next state are
    // set up on the edge that enters it, so read data arrives in the WT_* state
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            length_q    <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            pad_q       <= 8'd0;
            rdy_q       <= 1'b1;
            s_addr_q    <= 8'd0;
            s_wrdata_q  <= 8'd0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= 8'd0;
            pt_addr_q   <= 8'd0;
            pt_wrdata_q <= 8'd0;
            pt_wren_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en && rdy_q) begin
                        rdy_q     <= 1'b0;
                        i_q       <= 8'd0;
                        j_q       <= 8'd0;
                        k_q       <= 8'd0;
                        ct_addr_q <= 8'd0;
                        state_q   <= ST_RD_LEN;
                    end
                end

                ST_RD_LEN: begin
                    state_q <= ST_WT_LEN;
                end

                // CT[0] is on the read port: latch it and echo it to PT[0]
                ST_WT_LEN: begin
                    length_q    <= bus.ct_rddata;
                    pt_addr_q   <= 8'd0;
                    pt_wrdata_q <= bus.ct_rddata;
                    pt_wren_q   <= 1'b1;
                    state_q     <= ST_WR_LEN;
                end

                ST_WR_LEN: begin
                    pt_wren_q <= 1'b0;
                    if (length_q == 8'd0) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        k_q     <= 8'd1;
                        state_q <= ST_INC_I;
                    end
                end

                ST_INC_I: begin
                    i_q      <= i_d;
                    s_addr_q <= i_d;
                    state_q  <= ST_RD_SI;
                end

                ST_RD_SI: begin
                    state_q <= ST_WT_SI;
                end

                ST_WT_SI: begin
                    si_q    <= bus.s_rddata;
                    state_q <= ST_CALC_J;
                end

                ST_CALC_J: begin
                    j_q      <= j_d;
                    s_addr_q <= j_d;
                    state_q  <= ST_RD_SJ;
                end

                ST_RD_SJ: begin
                    state_q <= ST_WT_SJ;
                end

                // S[j] arrives: start the swap by writing it into S[i]
                ST_WT_SJ: begin
                    sj_q       <= bus.s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= bus.s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= ST_WR_SI;
                end

                // Second half of the swap; when i==j both writes hit one cell
                // with the same value, leaving S unchanged there
                ST_WR_SI: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    state_q    <= ST_WR_SJ;
                end

                ST_WR_SJ: begin
                    s_wren_q <= 1'b0;
                    s_addr_q <= pad_idx_d;
                    state_q  <= ST_RD_PAD;
                end

                ST_RD_PAD: begin
                    state_q <= ST_WT_PAD;
                end

                ST_WT_PAD: begin
                    pad_q     <= bus.s_rddata;
                    ct_addr_q <= k_q;
                    state_q   <= ST_RD_CT;
                end

                ST_RD_CT: begin
                    state_q <= ST_WT_CT;
                end

                ST_WT_CT: begin
                    pt_addr_q   <= k_q;
                    pt_wrdata_q <= pad_q ^ bus.ct_rddata;
                    pt_wren_q   <= 1'b1;
                    state_q     <= ST_WR_PT;
                end

                // Exit test happens before the increment so length=255 never
                // needs k to reach 256
                ST_WR_PT: begin
                    pt_wren_q <= 1'b0;
                    if (k_q == length_q) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        k_q     <= k_d;
                        state_q <= ST_INC_I;
                    end
                end

                default: begin
                    s_wren_q  <= 1'b0;
                    pt_wren_q <= 1'b0;
                    rdy_q     <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prga_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prga_core
//  Description : Self-checking bench for prga_core. Models the S/CT/PT
//                memories and compares against a plain software ARC4 model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prga_core;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prga_core_if bus ();

    prga_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory images (written by the stimulus) and the live memories
    logic [7:0] s_img  [256];
    logic [7:0] ct_img [256];
    logic [7:0] pt_img [256];
    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic       mem_load;

    int unsigned s_wr_cnt  = 0;
    int unsigned pt_wr_cnt = 0;

    // Single-port synchronous memories with one-cycle read latency
    always @(posedge clk) begin
        if (mem_load) begin
            s_mem  <= s_img;
            ct_mem <= ct_img;
            pt_mem <= pt_img;
        end else begin
            if (bus.s_wren) begin
                s_mem[bus.s_addr] <= bus.s_wrdata;
                s_wr_cnt <= s_wr_cnt + 1;
            end
            if (bus.pt_wren) begin
                pt_mem[bus.pt_addr] <= bus.pt_wrdata;
                pt_wr_cnt <= pt_wr_cnt + 1;
            end
        end
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.ct_rddata <= ct_mem[bus.ct_addr];
        bus.pt_rddata <= pt_mem[bus.pt_addr];
    end

    // Reference model state
    logic [7:0] m_s  [256];
    logic [7:0] m_pt [256];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic init_identity();
        for (int x = 0; x < 256; x++) s_img[x] = x[7:0];
    endtask

    // Standard ARC4 key schedule with a 3-byte key
    task automatic ksa(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb [3];
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        init_identity();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + s_img[x] + kb[x % 3];
            t = s_img[x];
            s_img[x] = s_img[j];
            s_img[j] = t;
        end
    endtask

    task automatic fill_ct(input logic [7:0] len);
        ct_img[0] = len;
        for (int x = 1; x < 256; x++) ct_img[x] = 8'($urandom);
        for (int x = 0; x < 256; x++) pt_img[x] = 8'($urandom);
    endtask

    // Push the images into the memories and seed the model from them
    task automatic load_mem();
        for (int x = 0; x < 256; x++) begin
            m_s[x]  = s_img[x];
            m_pt[x] = pt_img[x];
        end
        @(negedge clk);
        mem_load = 1'b1;
        @(negedge clk);
        mem_load = 1'b0;
    endtask

    // Software ARC4 keystream over the current model S
    task automatic model_run();
        logic [7:0] len;
        logic [7:0] i;
        logic [7:0] j;
        logic [7:0] si;
        logic [7:0] sj;
        logic [7:0] t;
        len = ct_img[0];
        m_pt[0] = len;
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            si = m_s[i];
            j = j + si;
            sj = m_s[j];
            m_s[i] = sj;
            m_s[j] = si;
            t = si + sj;
            m_pt[k] = m_s[t] ^ ct_img[k];
        end
    endtask

    task automatic run_dut(input int budget, output int cycles);
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        check("rdy_drop", 32'(bus.rdy), 32'd0);
        cycles = 1;
        while (bus.rdy !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("rdy_done", 32'(bus.rdy), 32'd1);
    endtask

    task automatic check_mems(input string name);
        for (int x = 0; x < 256; x++) begin
            check($sformatf("%s_pt[%0d]", name, x), 32'(pt_mem[x]), 32'(m_pt[x]));
            check($sformatf("%s_s[%0d]", name, x), 32'(s_mem[x]), 32'(m_s[x]));
        end
    endtask

    initial begin
        int cyc;
        int unsigned pt0;
        int unsigned s0;
        int rises;
        logic prev_rdy;

        rst_n    = 1'b1;
        bus.en   = 1'b1;
        bus.key  = 24'h0;
        mem_load = 1'b0;

        // ---------------- reset, en held high throughout ----------------
        init_identity();
        fill_ct(8'd5);
        load_mem();
        repeat (2) @(negedge clk);
        check("rst_rdy", 32'(bus.rdy), 32'd1);
        check("rst_s_wren", 32'(bus.s_wren), 32'd0);
        check("rst_pt_wren", 32'(bus.pt_wren), 32'd0);
        check("rst_addrs", {bus.s_addr, bus.ct_addr, bus.pt_addr, 8'h00}, 32'd0);
        check("rst_wrdata", {16'h0, bus.s_wrdata, bus.pt_wrdata}, 32'd0);
        check("rst_len", 32'(dut.length_q), 32'd0);
        pt0 = pt_wr_cnt;
        s0  = s_wr_cnt;
        bus.en = 1'b0;
        rst_n  = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_start", 32'(bus.rdy), 32'd1);
        check("rst_no_writes", pt_wr_cnt - pt0 + s_wr_cnt - s0, 32'd0);

        // ---------------- identity S, one byte ----------------
        init_identity();
        fill_ct(8'd1);
        ct_img[1] = 8'hAA;
        load_mem();
        model_run();
        run_dut(100, cyc);
        check("id_pt1", 32'(pt_mem[1]), 32'hA8);
        check("id_pt0", 32'(pt_mem[0]), 32'h01);
        for (int x = 0; x < 256; x++)
            check($sformatf("id_s[%0d]", x), 32'(s_mem[x]), x);
        check_mems("id");

        // ---------------- zero length ----------------
        ksa(24'($urandom));
        fill_ct(8'd0);
        load_mem();
        model_run();
        pt0 = pt_wr_cnt;
        s0  = s_wr_cnt;
        run_dut(20, cyc);
        check("len0_latency_ok", 32'(cyc <= 5), 32'd1);
        check("len0_pt_writes", pt_wr_cnt - pt0, 32'd1);
        check("len0_s_writes", s_wr_cnt - s0, 32'd0);
        check_mems("len0");

        // ---------------- length 0x19 ----------------
        ksa(24'($urandom));
        fill_ct(8'h19);
        load_mem();
        model_run();
        pt0 = pt_wr_cnt;
        s0  = s_wr_cnt;
        run_dut(2000, cyc);
        check("l19_length", 32'(dut.length_q), 32'h19);
        check("l19_k", 32'(dut.k_q), 32'h19);
        check("l19_pt_writes", pt_wr_cnt - pt0, 32'd26);
        check("l19_s_writes", s_wr_cnt - s0, 32'd50);
        check_mems("l19");

        // ---------------- golden key, then same data with other key input ----------------
        ksa(24'h1E4600);
        fill_ct(8'd32);
        bus.key = 24'h1E4600;
        load_mem();
        model_run();
        run_dut(2000, cyc);
        check_mems("gold");
        bus.key = 24'($urandom);
        load_mem();
        ksa(24'h1E4600);
        for (int x = 0; x < 256; x++) m_s[x] = s_img[x];
        model_run();
        run_dut(2000, cyc);
        check_mems("gold_key");

        // ---------------- length 255 (wrap of i, j, pad index, k exit) ----------------
        ksa(24'($urandom));
        fill_ct(8'd255);
        load_mem();
        model_run();
        run_dut(6000, cyc);
        check("l255_k", 32'(dut.k_q), 32'd255);
        check_mems("l255");

        // ---------------- reset mid-run, then restart ----------------
        ksa(24'($urandom));
        fill_ct(8'd40);
        load_mem();
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rdy", 32'(bus.rdy), 32'd1);
        check("mid_wrens", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
        rst_n = 1'b0;
        pt0 = pt_wr_cnt;
        s0  = s_wr_cnt;
        repeat (20) @(negedge clk);
        check("mid_quiet", pt_wr_cnt - pt0 + s_wr_cnt - s0, 32'd0);
        check("mid_idle_rdy", 32'(bus.rdy), 32'd1);
        ksa(24'($urandom));
        fill_ct(8'($urandom_range(1, 60)));
        load_mem();
        model_run();
        run_dut(2000, cyc);
        check_mems("restart");

        // ---------------- back-to-back starts with en held ----------------
        ksa(24'($urandom));
        fill_ct(8'd3);
        load_mem();
        model_run();
        model_run();
        @(negedge clk);
        bus.en   = 1'b1;
        rises    = 0;
        prev_rdy = 1'b1;
        cyc      = 0;
        while (rises < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (prev_rdy == 1'b0 && bus.rdy == 1'b1) rises++;
            prev_rdy = bus.rdy;
        end
        bus.en = 1'b0;
        check("b2b_runs", rises, 32'd2);
        repeat (3) @(negedge clk);
        check("b2b_idle", 32'(bus.rdy), 32'd1);
        check_mems("b2b");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
